// File: rtl/restador_arbiter.sv
// ============================================================================
// restador_arbiter : two-port round-robin front end for a shared subtractor
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module restador_arbiter #(
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req0_valid_i,
   output logic              req0_ready_o,
   input  logic [DATA_W-1:0] req0_a_i,
   input  logic [DATA_W-1:0] req0_b_i,
   output logic              rsp0_valid_o,
   input  logic              rsp0_ready_i,
   input  logic              req1_valid_i,
   output logic              req1_ready_o,
   input  logic [DATA_W-1:0] req1_a_i,
   input  logic [DATA_W-1:0] req1_b_i,
   output logic              rsp1_valid_o,
   input  logic              rsp1_ready_i,
   output logic [DATA_W-1:0] result_o,
   output logic              borrow_o,
   output logic              zero_o,
   output logic              busy_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            state_q;
   logic              last_q;
   logic              owner_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] result_q;
   logic              borrow_q;
   logic              zero_q;
   logic              rsp0_valid_q;
   logic              rsp1_valid_q;
   logic              busy_q;

   logic              idle;
   logic              gnt1;
   logic              rsp_done;
   logic [DATA_W:0]   diff_d;

   // On a tie, the port that was not served last wins; reset leaves last_q=1.
   assign idle         = (state_q == S_IDLE);
   assign gnt1         = req1_valid_i & (~req0_valid_i | ~last_q);
   assign req0_ready_o = idle & req0_valid_i & ~gnt1;
   assign req1_ready_o = idle & gnt1;

   assign rsp_done = owner_q ? rsp1_ready_i : rsp0_ready_i;
   assign diff_d   = {1'b0, a_q} - {1'b0, b_q};

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         last_q       <= 1'b1;
         owner_q      <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         result_q     <= '0;
         borrow_q     <= 1'b0;
         zero_q       <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req0_ready_o | req1_ready_o) begin
                  a_q     <= gnt1 ? req1_a_i : req0_a_i;
                  b_q     <= gnt1 ? req1_b_i : req0_b_i;
                  owner_q <= gnt1;
                  busy_q  <= 1'b1;
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               result_q     <= diff_d[DATA_W-1:0];
               borrow_q     <= diff_d[DATA_W];
               zero_q       <= (diff_d[DATA_W-1:0] == '0);
               rsp0_valid_q <= ~owner_q;
               rsp1_valid_q <= owner_q;
               state_q      <= S_RESP;
            end
            S_RESP: begin
               if (rsp_done) begin
                  rsp0_valid_q <= 1'b0;
                  rsp1_valid_q <= 1'b0;
                  last_q       <= owner_q;
                  busy_q       <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end
            default: begin
               rsp0_valid_q <= 1'b0;
               rsp1_valid_q <= 1'b0;
               busy_q       <= 1'b0;
               state_q      <= S_IDLE;
            end
         endcase
      end
   end

   assign rsp0_valid_o = rsp0_valid_q;
   assign rsp1_valid_o = rsp1_valid_q;
   assign result_o     = result_q;
   assign borrow_o     = borrow_q;
   assign zero_o       = zero_q;
   assign busy_o       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_restador_arbiter.sv
// ============================================================================
// tb_restador_arbiter : directed and random checks against a transaction model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_restador_arbiter;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       req0_valid_i = 1'b0, req1_valid_i = 1'b0;
   logic [7:0] req0_a_i = '0, req0_b_i = '0, req1_a_i = '0, req1_b_i = '0;
   logic       rsp0_ready_i = 1'b0, rsp1_ready_i = 1'b0;
   logic       req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o;
   logic [7:0] result_o;
   logic       borrow_o, zero_o, busy_o;

   restador_arbiter #(.DATA_W(8)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
      .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
      .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i),
      .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
      .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
      .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i),
      .result_o(result_o), .borrow_o(borrow_o), .zero_o(zero_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // Transaction-level model: one job in flight, aged in cycles since acceptance.
   bit m_known = 0;
   bit m_inflight = 0;
   int m_age = 0;
   int m_owner = 0;
   int m_last = 1;
   int p_res = 0, p_bor = 0, p_zero = 0;
   int s_res = 0, s_bor = 0, s_zero = 0;
   int obs_grants[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit rst, input bit v0, input bit v1,
                       input logic [7:0] a0, input logic [7:0] b0,
                       input logic [7:0] a1, input logic [7:0] b1,
                       input bit rr0, input bit rr1);
      int win;
      logic [7:0] wa, wb;
      @(negedge clk_i);
      if (m_known) begin
         chk("busy", busy_o, m_inflight);
         chk("rsp0_valid", rsp0_valid_o, m_inflight && m_age == 2 && m_owner == 0);
         chk("rsp1_valid", rsp1_valid_o, m_inflight && m_age == 2 && m_owner == 1);
         chk("result", result_o, s_res);
         chk("borrow", borrow_o, s_bor);
         chk("zero", zero_o, s_zero);
      end
      if (!rst) begin
         v0 = 0;
         v1 = 0;
      end
      rst_ni = rst;
      req0_valid_i = v0; req0_a_i = a0; req0_b_i = b0;
      req1_valid_i = v1; req1_a_i = a1; req1_b_i = b1;
      rsp0_ready_i = rr0; rsp1_ready_i = rr1;
      #1;
      win = -1;
      if (!m_inflight) begin
         if (v0 && v1) win = (m_last == 0) ? 1 : 0;
         else if (v0)  win = 0;
         else if (v1)  win = 1;
      end
      if (m_known) begin
         chk("req0_ready", req0_ready_o, win == 0);
         chk("req1_ready", req1_ready_o, win == 1);
      end
      if (rst && (req0_ready_o || req1_ready_o)) obs_grants.push_back(req1_ready_o ? 1 : 0);
      if (!rst) begin
         m_known = 1; m_inflight = 0; m_age = 0; m_last = 1;
         s_res = 0; s_bor = 0; s_zero = 0;
      end else if (m_inflight) begin
         if (m_age == 1) begin
            m_age = 2; s_res = p_res; s_bor = p_bor; s_zero = p_zero;
         end else if ((m_owner == 0) ? rr0 : rr1) begin
            m_inflight = 0; m_last = m_owner;
         end
      end else if (win >= 0) begin
         wa = (win == 1) ? a1 : a0;
         wb = (win == 1) ? b1 : b0;
         m_inflight = 1; m_age = 1; m_owner = win;
         p_res  = (int'(wa) - int'(wb) + 256) % 256;
         p_bor  = (wa < wb) ? 1 : 0;
         p_zero = (p_res == 0) ? 1 : 0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 1);
   endtask

   task automatic do_reset();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Single transaction on one port with literal expected response.
   task automatic txn(input int port, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input bit eb, input bit ez);
      step(1, port == 0, port == 1, a, b, a, b, 1, 1);
      chk("txn_req_ready", (port == 0) ? req0_ready_o : req1_ready_o, 1);
      step(1, 0, 0, 0, 0, 0, 0, 1, 1);
      step(1, 0, 0, 0, 0, 0, 0, 1, 1);
      chk("txn_rsp_valid", (port == 0) ? rsp0_valid_o : rsp1_valid_o, 1);
      chk("txn_other_valid", (port == 0) ? rsp1_valid_o : rsp0_valid_o, 0);
      chk("txn_result", result_o, er);
      chk("txn_borrow", borrow_o, eb);
      chk("txn_zero", zero_o, ez);
   endtask

   initial begin
      int exp_pat[4];
      exp_pat = '{0, 1, 0, 1};

      do_reset();
      chk("reset_busy", busy_o, 0);
      chk("reset_result", result_o, 0);

      txn(0, 8'h2A, 8'h0F, 8'h1B, 0, 0);
      txn(1, 8'h05, 8'h07, 8'hFE, 1, 0);
      txn(1, 8'h33, 8'h33, 8'h00, 0, 1);

      do_reset();
      obs_grants.delete();
      for (int i = 0; i < 12; i++) step(1, 1, 1, 8'h10 + 8'(i), 8'h03, 8'h40, 8'(i), 1, 1);
      chk("rr_count", obs_grants.size(), 4);
      for (int i = 0; i < 4 && i < obs_grants.size(); i++) chk("rr_order", obs_grants[i], exp_pat[i]);

      // Response back-pressure while the other port waits.
      step(1, 1, 0, 8'h90, 8'h11, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 8'h01, 8'h01, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 1, 0, 0, 8'h01, 8'h01, 0, 0);
         chk("bp_req1_ready", req1_ready_o, 0);
         chk("bp_rsp0_valid", rsp0_valid_o, 1);
         chk("bp_result", result_o, 8'h7F);
      end
      step(1, 0, 1, 0, 0, 8'h01, 8'h01, 1, 0);
      step(1, 0, 1, 0, 0, 8'h01, 8'h01, 1, 1);
      chk("bp_back_idle", busy_o, 0);
      idle(4);

      // Reset during EXEC, then during RESP.
      step(1, 1, 0, 8'h77, 8'h22, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle(3);
      chk("rst_exec_busy", busy_o, 0);
      chk("rst_exec_result", result_o, 0);
      step(1, 0, 1, 0, 0, 8'h01, 8'h05, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      chk("rst_resp_rsp1", rsp1_valid_o, 0);
      chk("rst_resp_borrow", borrow_o, 0);

      txn(0, 8'hFF, 8'h00, 8'hFF, 0, 0);
      txn(0, 8'h00, 8'hFF, 8'h01, 1, 0);
      txn(0, 8'h80, 8'h01, 8'h7F, 0, 0);
      txn(0, 8'h00, 8'h00, 8'h00, 0, 1);

      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) != 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      end
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
